wb_master_bridge: RTL and testbench
===================================

Name: wb_master_bridge

Overview:
Single-outstanding Wishbone classic initiator. It turns valid/ready command transfers into Wishbone read/write cycles toward the SoC peripherals (GPIO, SRAM) and returns each result on a valid/ready response channel. It sits between a debug/command source (UART bridge, test sequencer) and the peripheral bus.

Parameters:
AW, 32, address width of cmd_addr / o_wb_adr
DW, 32, data width; must be a multiple of 8
TIMEOUT, 255, number of BUS-state cycles without ack before abort (used only with the optional feature)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  bridge accepts a command this cycle
cmd_we  input  1  1 = write, 0 = read
cmd_addr  input  AW  target address
cmd_wdat  input  DW  write data
cmd_sel  input  DW/8  byte selects
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_rdat  output  DW  read data; 0 for writes
rsp_err  output  1  1 = transaction aborted by timeout
o_wb_cyc  output  1  Wishbone cycle
o_wb_stb  output  1  Wishbone strobe
o_wb_we  output  1  Wishbone write enable
o_wb_adr  output  AW  Wishbone address
o_wb_dat  output  DW  Wishbone write data
o_wb_sel  output  DW/8  Wishbone byte selects
i_wb_rdt  input  DW  Wishbone read data
i_wb_ack  input  1  Wishbone acknowledge
busy  output  1  high in BUS or RESP state

Behaviour:
- Reset: state = IDLE. All outputs are 0 except cmd_ready, which is 1.
- All outputs are registered, except cmd_ready = (state == IDLE).
- Transfers complete on a posedge where valid && ready.
- IDLE:
  - Command accepted on cmd_valid.
  - cmd_we/addr/wdat/sel are latched into o_wb_we/adr/dat/sel.
  - o_wb_cyc = o_wb_stb = 1 from the next cycle; state -> BUS.
- BUS:
  - o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat and o_wb_sel are held constant.
  - When i_wb_ack = 1 is sampled: cyc and stb drop on that edge, so they are low in the next cycle. Peripherals that toggle ack while cyc stays high must never see a second cycle.
  - On that same edge: rsp_rdat <= (we ? 0 : i_wb_rdt), rsp_err <= 0, rsp_valid <= 1, state -> RESP.
- RESP:
  - rsp_valid, rsp_rdat and rsp_err are held until rsp_ready.
  - On the handshake: rsp_valid <= 0, rsp_rdat <= 0, state -> IDLE.
  - cmd_ready is low throughout; no new command is accepted until the cycle after the response is consumed.
- i_wb_ack is ignored whenever o_wb_cyc = 0. A stray ack in IDLE or RESP has no effect.
- Minimum latency (1-cycle-ack slave, rsp_ready held high): command accepted at edge 0, cyc high in cycle 1, ack sampled at edge 2, rsp_valid high in cycle 2, back in IDLE after edge 3.
- Reset mid-transaction: cyc/stb low after the reset edge, any pending response is discarded, state -> IDLE.
- Exactly one transaction is outstanding at a time; there is no pipelining and no burst.

Optional Feature:
WB_MASTER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter = TIMEOUT-1 and ack is 0, the bridge aborts: cyc/stb drop, rsp_err <= 1, rsp_rdat <= 0, state -> RESP.
  - If ack arrives on the expiry cycle, ack wins and rsp_err = 0.
  - The counter width is $clog2(TIMEOUT+1).
- Undefined:
  - No counter exists; BUS waits for ack indefinitely.
  - rsp_err is constant 0 and TIMEOUT is unused.

Test Plan:
- Write: cmd addr=0x1, wdat=0xA5, sel=0xF, we=1 against a 1-cycle-ack slave -> exactly one cyc/stb cycle with adr=0x1, dat=0xA5; rsp_valid with rsp_rdat=0, rsp_err=0; cyc never asserted twice.
- Read: slave returns 0x3C on ack, rsp_ready high -> rsp_rdat=0x3C, rsp_err=0; command accepted at edge 0, back in IDLE (cmd_ready=1) after edge 3.
- Backpressure: rsp_ready held low 10 cycles after a read of 0x77 -> rsp_valid/rsp_rdat stable for 10 cycles, cmd_ready=0, a new cmd_valid is not accepted; accepted the cycle after rsp_ready rises.
- Timeout (macro defined, TIMEOUT=8): slave never acks -> cyc high exactly 8 cycles, then rsp_err=1, rsp_rdat=0; with ack arriving on the 8th cycle -> rsp_err=0 and data is returned.
- Reset mid-BUS: assert rst for 1 cycle while cyc=1 -> cyc/stb=0 and rsp_valid=0 next cycle, cmd_ready=1; a later ack is ignored.
- Stray ack: pulse i_wb_ack in IDLE and in RESP -> no state change, no response change.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator fed by valid/ready command and response channels.
// Define WB_MASTER_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT cycles.
module wb_master_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdat,
    output logic            rsp_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_adr,
    output logic [DW-1:0]   o_wb_dat,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic [DW-1:0]   i_wb_rdt,
    input  logic            i_wb_ack,
    output logic            busy
);

    localparam int SW = DW / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdat_q, rsp_rdat_d;
    logic          busy_q, busy_d;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d;
`else
    // TIMEOUT has no effect when the abort counter is not built.
    localparam int unused_timeout = TIMEOUT;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves one unassigned (no latches).
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdat_d  = rsp_rdat_q;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_addr;
                    dat_d   = cmd_wdat;
                    sel_d   = cmd_sel;
                    cyc_d   = 1'b1;
                    state_d = S_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUS: begin
                // Dropping cyc on the ack edge keeps a lingering ack from starting a second cycle.
                if (i_wb_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdat_d  = we_q ? '0 : i_wb_rdt;
                    state_d     = S_RESP;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdat_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdat_d  = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples the pre-edge value of every other.
        if (rst) begin
            // NOTE: the bus-side registers are reset too because every output must read 0 out of reset.
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdat_q  <= '0;
            busy_q      <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdat_q  <= rsp_rdat_d;
            busy_q      <= busy_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = cyc_q;
    assign o_wb_we   = we_q;
    assign o_wb_adr  = adr_q;
    assign o_wb_dat  = dat_q;
    assign o_wb_sel  = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdat  = rsp_rdat_q;
    assign busy      = busy_q;
`ifdef WB_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: directed scenarios plus randomized transactions
// checked against a transaction-level model of bus length, latency and response contents.
module tb_wb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 8;
    localparam int MAX_BUS = 64;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdat = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdat;
    logic          rsp_err;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_adr;
    logic [DW-1:0] o_wb_dat;
    logic [SW-1:0] o_wb_sel;
    logic [DW-1:0] i_wb_rdt = '0;
    logic          i_wb_ack = 1'b0;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdat(cmd_wdat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdat(rsp_rdat), .rsp_err(rsp_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a bus cycle lasts until the ack cycle, or TIMEOUT cycles when aborting.
    function automatic bit times_out(input int ack_dly);
        return TO_EN && (ack_dly < 0 || ack_dly >= T);
    endfunction

    function automatic int exp_bus_cycles(input int ack_dly);
        return times_out(ack_dly) ? T : ack_dly + 1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, cmd_ready, 1'b1);
        check({tag, "_cyc"},   o_wb_cyc,  1'b0);
        check({tag, "_stb"},   o_wb_stb,  1'b0);
        check({tag, "_rspv"},  rsp_valid, 1'b0);
        check({tag, "_busy"},  busy,      1'b0);
    endtask

    // One full transaction; ack_dly < 0 means the slave never acks. edges = posedges from accept to handshake.
    task automatic do_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] sel, input int ack_dly, input logic [DW-1:0] rd,
                          input int bp, output int edges);
        int            cyc_cnt;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        exp_err = times_out(ack_dly);
        exp_rd  = (we || exp_err) ? '0 : rd;

        check("acc_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = adr; cmd_wdat = wd; cmd_sel = sel;
        rsp_ready = 1'b0;
        tick();

        cyc_cnt = 0;
        while (!rsp_valid && cyc_cnt < MAX_BUS) begin
            check("bus_cyc", o_wb_cyc, 1'b1);
            check("bus_stb", o_wb_stb, 1'b1);
            check("bus_we",  o_wb_we,  we);
            check("bus_adr", o_wb_adr, adr);
            check("bus_dat", o_wb_dat, wd);
            check("bus_sel", o_wb_sel, sel);
            check("bus_ready", cmd_ready, 1'b0);
            check("bus_busy", busy, 1'b1);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdat  = $urandom;
            cmd_sel   = SW'($urandom);
            i_wb_ack  = (cyc_cnt == ack_dly);
            i_wb_rdt  = i_wb_ack ? rd : $urandom;
            rsp_ready = (bp == 0);
            tick();
            cyc_cnt++;
        end
        i_wb_ack  = 1'b0;
        cmd_valid = 1'b0;

        check("bus_len",  cyc_cnt,   exp_bus_cycles(ack_dly));
        check("rsp_v",    rsp_valid, 1'b1);
        check("rsp_dat",  rsp_rdat,  exp_rd);
        check("rsp_err",  rsp_err,   exp_err);
        check("rsp_cyc",  o_wb_cyc,  1'b0);
        check("rsp_stb",  o_wb_stb,  1'b0);
        check("rsp_rdy",  cmd_ready, 1'b0);
        check("rsp_busy", busy,      1'b1);

        // Backpressure with stray acks and competing commands: nothing may move.
        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            i_wb_ack  = 1'($urandom_range(0, 1));
            i_wb_rdt  = $urandom;
            tick();
            check("bp_v",   rsp_valid, 1'b1);
            check("bp_dat", rsp_rdat,  exp_rd);
            check("bp_err", rsp_err,   exp_err);
            check("bp_cyc", o_wb_cyc,  1'b0);
            check("bp_rdy", cmd_ready, 1'b0);
        end

        rsp_ready = 1'b1;
        i_wb_ack  = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = $urandom;
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("hs_v",   rsp_valid, 1'b0);
        check("hs_dat", rsp_rdat,  '0);
        check_idle("hs");
        edges = cyc_cnt + bp + 1;
    endtask

    initial begin
        int edges;
        int dly;

        rst = 1'b1;
        tick();
        tick();
        check_idle("reset");
        check("reset_we",  o_wb_we,  1'b0);
        check("reset_adr", o_wb_adr, '0);
        check("reset_dat", o_wb_dat, '0);
        check("reset_sel", o_wb_sel, '0);
        check("reset_rd",  rsp_rdat, '0);
        check("reset_err", rsp_err,  1'b0);
        rst = 1'b0;
        tick();

        // Stray ack while idle.
        i_wb_ack = 1'b1;
        i_wb_rdt = 32'hDEAD_BEEF;
        tick();
        i_wb_ack = 1'b0;
        check_idle("stray_idle");
        check("stray_idle_rd", rsp_rdat, '0);

        do_txn(1'b1, 32'h1, 32'hA5, 4'hF, 0, 32'h1234_5678, 0, edges);
        check("write_latency", edges, 2);

        do_txn(1'b0, 32'h40, 32'h0, 4'hF, 1, 32'h3C, 0, edges);
        check("read_latency", edges, 3);

        do_txn(1'b0, 32'h80, 32'h0, 4'h3, 2, 32'h77, 10, edges);
        check("bp_latency", edges, 3 + 1 + 10);

`ifdef WB_MASTER_TIMEOUT_EN
        do_txn(1'b0, 32'hC0, 32'h0, 4'hF, -1, 32'h55, 1, edges);
        check("to_latency", edges, T + 1 + 1);
        do_txn(1'b0, 32'hC4, 32'h0, 4'hF, T - 1, 32'h99, 0, edges);
        check("to_ack_wins_latency", edges, T + 1);
`endif

        // Reset in the middle of a bus cycle, then a late ack.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h100; cmd_sel = 4'hF;
        tick();
        cmd_valid = 1'b0;
        check("mid_cyc", o_wb_cyc, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_rst");
        i_wb_ack = 1'b1;
        i_wb_rdt = 32'hCAFE;
        tick();
        i_wb_ack = 1'b0;
        check_idle("late_ack");
        check("late_ack_rd", rsp_rdat, '0);

        for (int n = 0; n < 40; n++) begin
            dly = $urandom_range(0, TO_EN ? 10 : 5);
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom), dly, $urandom,
                   $urandom_range(0, 3), edges);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
